srl_fifo: RTL and testbench
===========================

Name: srl_fifo

Overview:
Parametrised FIFO built on an addressable shift-register store, the next generation of our SRL16E primitive. Storage is one WIDTH x DEPTH shift register: every accepted write shifts it, and the oldest entry is read through a mux addressed by the fill level. It adds valid/ready handshakes, occupancy tracking, flags and flush, none of which the fixed 16x1 SRL has. Used as a small elastic buffer between pipeline stages in our Verilator-simulated Xilinx designs.

Parameters:
WIDTH, 8, data bits per entry (1..64)
DEPTH, 16, entries; power of two, 2..256
AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when LEVEL >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, ALMOST_EMPTY asserts when LEVEL <= AE_LEVEL (0..DEPTH-1)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous clear of contents
S_DATA  in  WIDTH  write data
S_VALID  in  1  write request
S_READY  out  1  space available (= LEVEL != DEPTH)
M_DATA  out  WIDTH  oldest entry (show-ahead)
M_VALID  out  1  data available (= LEVEL != 0)
M_READY  in  1  read acknowledge
LEVEL  out  clog2(DEPTH+1)  current occupancy
ALMOST_FULL  out  1  LEVEL >= AF_LEVEL
ALMOST_EMPTY  out  1  LEVEL <= AE_LEVEL

Behaviour:
- Reset: RST_N low clears LEVEL to 0 immediately, asynchronously. While reset is held: S_READY=1, M_VALID=0, M_DATA=0, ALMOST_FULL=0 (AF_LEVEL>=1), ALMOST_EMPTY=1. Deassertion is sampled synchronously; the first push is accepted on the first rising edge with RST_N high.
- Storage array is not reset, matching SRL hardware. Its contents after reset or flush are don't-care and must never be visible on M_DATA.
- push = S_VALID & S_READY; pop = M_VALID & M_READY.
- On push: shift the store (entry[i] <= entry[i-1], entry[0] <= S_DATA). With no push, the store holds.
- Read address = LEVEL-1. M_DATA = entry[LEVEL-1] when LEVEL != 0, else 0. The path is combinational from the LEVEL register and the store; there is no output register.
- LEVEL update, in priority order:
  - FLUSH: LEVEL <= 0.
  - push & ~pop: LEVEL+1.
  - pop & ~push: LEVEL-1.
  - otherwise: unchanged.
- FLUSH overrides push and pop in the same cycle; no data is accepted. S_READY and M_VALID are not gated by FLUSH.
- Simultaneous push and pop with 0 < LEVEL < DEPTH: the store shifts and LEVEL is unchanged, so the read address is unchanged. The next M_DATA is the next-oldest entry.
- Full (LEVEL = DEPTH): S_READY=0, so a push is impossible. A pop in the same cycle does not enable a same-cycle push; there is no full pass-through. S_READY rises the cycle after the pop.
- Empty (LEVEL = 0): M_VALID=0, so a pop is impossible. There is no write-to-read bypass.
- Latency: data written at edge N appears on M_DATA with M_VALID=1 after edge N (1 cycle).
- Flags are combinational decodes of the LEVEL register and therefore glitch-free relative to CLK.
- Ordering is strict FIFO. Data is never dropped or duplicated.
- S_VALID and M_READY may change freely; the block places no stability requirement on the requester.
- Width rules: LEVEL holds 0..DEPTH inclusive, so it is clog2(DEPTH+1) bits wide. The read mux index is clog2(DEPTH) bits.

Test Plan:
- Reset then write 0x11,0x22,0x33 on consecutive cycles with M_READY=0 -> LEVEL=3, M_DATA=0x11, M_VALID=1. Then M_READY=1 for 3 cycles -> M_DATA reads 0x22, then 0x33, then LEVEL=0, M_VALID=0, M_DATA=0.
- Fill DEPTH=16 with 0x00..0x0F -> S_READY=0 and LEVEL=16 after the 16th edge. Hold S_VALID=1 with 0xFF and pop once -> 0xFF is not accepted that cycle, S_READY=1 the next cycle, then 0xFF is accepted as the last entry.
- At LEVEL=5, drive push and pop continuously for 20 cycles with an incrementing pattern -> LEVEL stays 5 and the output sequence is exactly the input sequence delayed by 5 accepts.
- Flags with AF_LEVEL=14, AE_LEVEL=2: step LEVEL 0->16->0 -> ALMOST_EMPTY high for LEVEL<=2, ALMOST_FULL high for LEVEL>=14, transitions on the exact edge where LEVEL crosses the threshold.
- At LEVEL=7, assert FLUSH together with S_VALID=1 and M_READY=1 -> next cycle LEVEL=0, M_VALID=0; the written word is discarded.
- Pull RST_N low mid-stream at LEVEL=9, between edges -> LEVEL=0, M_VALID=0 and S_READY=1 immediately without a clock edge. After release, the first write reads back correctly.
- Randomised push/pop against a queue model for DEPTH=2 and DEPTH=256, 10k cycles -> no mismatch, no overflow or underflow.

Source files
------------

// File: rtl/srl_fifo.sv
`timescale 1ns/1ps
// srl_fifo: small elastic FIFO built on an addressable shift-register store.
// Every accepted write shifts the whole store by one entry; the oldest entry
// sits at index LEVEL-1 and is read through a combinational mux (show-ahead).
//
// Handshake: a write is accepted on a rising edge when S_VALID & S_READY,
// a read is consumed on a rising edge when M_VALID & M_READY. Both ready and
// valid are pure decodes of the occupancy register, so neither depends
// combinationally on the opposite side's request; requesters may change
// S_VALID / M_READY freely between edges.
module srl_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int LW      = $clog2(DEPTH + 1),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] S_DATA,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic [WIDTH-1:0] M_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [LW-1:0]    LEVEL,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY
);

    // Storage is deliberately not reset: its contents are masked by LEVEL.
    logic [WIDTH-1:0] store_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [AW-1:0]    rd_addr;
    logic             push;
    logic             pop;
    logic             wr_en;

    // Ready/valid come straight from the occupancy register, never from FLUSH.
    assign S_READY = (level_q != LW'(DEPTH));
    assign M_VALID = (level_q != '0);

    assign push  = S_VALID & S_READY;
    assign pop   = M_VALID & M_READY;
    // A flush discards the incoming word, so the store is left untouched.
    assign wr_en = push & ~FLUSH;

    // Next occupancy: flush wins, a simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        if (FLUSH) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Occupancy register; reset clears it without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Shift-register store: new data enters at index 0, older data moves up.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                store_q[i] <= store_q[i-1];
            end
            store_q[0] <= S_DATA;
        end
    end

    // Oldest entry lives at LEVEL-1; LEVEL wraps harmlessly when empty
    // because the output is forced to zero in that case.
    assign rd_addr = AW'(level_q - LW'(1));
    assign M_DATA  = M_VALID ? store_q[rd_addr] : '0;

    assign LEVEL        = level_q;
    assign ALMOST_FULL  = (level_q >= LW'(AF_LEVEL));
    assign ALMOST_EMPTY = (level_q <= LW'(AE_LEVEL));

endmodule

// File: tb/tb_srl_fifo.sv
`timescale 1ns/1ps
// Self-checking bench for srl_fifo: directed scenarios on a DEPTH=16 instance
// plus randomised traffic on DEPTH=2 and DEPTH=256 instances, all checked by
// per-instance queue models sampled on the falling clock edge.
module tb_srl_fifo;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int LW = $clog2(D + 1);
    localparam int AF = 14;
    localparam int AE = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          rand_rst_n;
    logic          flush;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          af;
    logic          ae;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];

    srl_fifo #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
        .S_DATA(s_data), .S_VALID(s_valid), .S_READY(s_ready),
        .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready),
        .LEVEL(level), .ALMOST_FULL(af), .ALMOST_EMPTY(ae)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for the DEPTH=16 instance ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("level", 64'(level), 64'(exp_q.size()));
            check("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
            check("s_ready", 64'(s_ready), 64'(exp_q.size() != D));
            check("almost_full", 64'(af), 64'(exp_q.size() >= AF));
            check("almost_empty", 64'(ae), 64'(exp_q.size() <= AE));
            if (exp_q.size() != 0) check("m_data", 64'(m_data), 64'(exp_q[0]));
            else                   check("m_data_idle", 64'(m_data), 64'(0));
            if (flush) begin
                exp_q.delete();
            end else begin
                logic do_push;
                do_push = s_valid && (exp_q.size() != D);
                if (m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(s_data);
            end
        end
    end

    // ---------------- randomised instances: DEPTH=2 and DEPTH=256 ----------------
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int RD  = (g == 0) ? 2 : 256;
        localparam int RLW = $clog2(RD + 1);
        localparam int RAF = (g == 0) ? 2 : RD - 2;
        localparam int RAE = (g == 0) ? 1 : 2;

        logic           r_flush, r_sv, r_sr, r_mv, r_mr, r_af, r_ae;
        logic [W-1:0]   r_sd, r_md;
        logic [RLW-1:0] r_lvl;
        logic [W-1:0]   q[$];
        logic           done;

        srl_fifo #(
            .WIDTH(W), .DEPTH(RD), .AF_LEVEL(RAF), .AE_LEVEL(RAE)
        ) u_dut (
            .CLK(clk), .RST_N(rand_rst_n), .FLUSH(r_flush),
            .S_DATA(r_sd), .S_VALID(r_sv), .S_READY(r_sr),
            .M_DATA(r_md), .M_VALID(r_mv), .M_READY(r_mr),
            .LEVEL(r_lvl), .ALMOST_FULL(r_af), .ALMOST_EMPTY(r_ae)
        );

        initial begin
            done    = 1'b0;
            r_flush = 1'b0;
            r_sv    = 1'b0;
            r_mr    = 1'b0;
            r_sd    = '0;
            wait (rand_rst_n === 1'b1);
            for (int c = 0; c < 10000; c++) begin
                int seg;
                @(posedge clk);
                #1;
                // Alternate fill-biased and drain-biased phases to reach both ends.
                seg     = (c / 1000) % 2;
                r_sv    = ($urandom_range(0, 99) < ((seg == 0) ? 75 : 25));
                r_mr    = ($urandom_range(0, 99) < ((seg == 0) ? 25 : 75));
                r_flush = ($urandom_range(0, 999) == 0);
                r_sd    = W'($urandom_range(0, 255));
            end
            @(posedge clk);
            #1;
            r_sv    = 1'b0;
            r_mr    = 1'b0;
            r_flush = 1'b0;
            done    = 1'b1;
        end

        always @(negedge clk) begin
            if (rand_rst_n) begin
                check($sformatf("r%0d_level", RD), 64'(r_lvl), 64'(q.size()));
                check($sformatf("r%0d_m_valid", RD), 64'(r_mv), 64'(q.size() != 0));
                check($sformatf("r%0d_s_ready", RD), 64'(r_sr), 64'(q.size() != RD));
                check($sformatf("r%0d_af", RD), 64'(r_af), 64'(q.size() >= RAF));
                check($sformatf("r%0d_ae", RD), 64'(r_ae), 64'(q.size() <= RAE));
                if (q.size() != 0) check($sformatf("r%0d_m_data", RD), 64'(r_md), 64'(q[0]));
                else               check($sformatf("r%0d_m_data_idle", RD), 64'(r_md), 64'(0));
                if (r_flush) begin
                    q.delete();
                end else begin
                    logic do_push;
                    do_push = r_sv && (q.size() != RD);
                    if (r_mr && q.size() != 0) void'(q.pop_front());
                    if (do_push) q.push_back(r_sd);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        rand_rst_n = 1'b0;
        flush      = 1'b0;
        s_data     = '0;
        s_valid    = 1'b0;
        m_ready    = 1'b0;

        // Reset held: outputs must show the empty state.
        #2;
        check("rst_level", 64'(level), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(1));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_af", 64'(af), 64'(0));
        check("rst_ae", 64'(ae), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        rand_rst_n = 1'b1;

        // Three writes, then three reads.
        s_valid = 1'b1; s_data = 8'h11; tick();
        s_data = 8'h22; tick();
        s_data = 8'h33; tick();
        s_valid = 1'b0;
        check("t1_level", 64'(level), 64'(3));
        check("t1_m_data", 64'(m_data), 64'(8'h11));
        check("t1_m_valid", 64'(m_valid), 64'(1));
        m_ready = 1'b1; tick();
        check("t1_rd1", 64'(m_data), 64'(8'h22));
        tick();
        check("t1_rd2", 64'(m_data), 64'(8'h33));
        tick();
        check("t1_empty_level", 64'(level), 64'(0));
        check("t1_empty_valid", 64'(m_valid), 64'(0));
        check("t1_empty_data", 64'(m_data), 64'(0));
        m_ready = 1'b0;

        // Fill to DEPTH, then no pass-through while full.
        for (int i = 0; i < D; i++) begin
            s_valid = 1'b1; s_data = W'(i); tick();
        end
        check("t2_full_ready", 64'(s_ready), 64'(0));
        check("t2_full_level", 64'(level), 64'(D));
        s_data = 8'hFF; m_ready = 1'b1; tick();
        check("t2_no_passthru_level", 64'(level), 64'(D - 1));
        check("t2_ready_back", 64'(s_ready), 64'(1));
        m_ready = 1'b0; tick();
        check("t2_ff_accepted", 64'(level), 64'(D));
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (D) tick();
        check("t2_drained", 64'(level), 64'(0));
        m_ready = 1'b0;

        // Streaming at LEVEL=5: push and pop every cycle.
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = W'(8'hA0 + i); tick();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int idx;
            s_data = W'(8'h40 + i); tick();
            idx = i + 1;
            check("t3_level", 64'(level), 64'(5));
            check("t3_m_data", 64'(m_data), (idx < 5) ? 64'(8'hA0 + idx) : 64'(8'h40 + idx - 5));
        end
        s_valid = 1'b0;
        repeat (5) tick();
        m_ready = 1'b0;

        // Flag thresholds while stepping 0 -> 16 -> 0.
        for (int i = 1; i <= D; i++) begin
            s_valid = 1'b1; s_data = W'(8'hC0 + i); tick();
            check("t4_af_up", 64'(af), 64'(i >= AF));
            check("t4_ae_up", 64'(ae), 64'(i <= AE));
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = D - 1; i >= 0; i--) begin
            tick();
            check("t4_af_dn", 64'(af), 64'(i >= AF));
            check("t4_ae_dn", 64'(ae), 64'(i <= AE));
        end
        m_ready = 1'b0;

        // Flush at LEVEL=7 together with a push and a pop.
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = W'(8'h70 + i); tick();
        end
        s_data = 8'hEE; m_ready = 1'b1; flush = 1'b1; tick();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        check("t5_level", 64'(level), 64'(0));
        check("t5_m_valid", 64'(m_valid), 64'(0));
        s_valid = 1'b1; s_data = 8'h5A; tick();
        s_valid = 1'b0;
        check("t5_after_level", 64'(level), 64'(1));
        check("t5_after_data", 64'(m_data), 64'(8'h5A));
        m_ready = 1'b1; tick(); m_ready = 1'b0;

        // Asynchronous reset mid-stream at LEVEL=9.
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_data = W'(8'h90 + i); tick();
        end
        s_valid = 1'b0; tick();
        check("t6_pre_level", 64'(level), 64'(9));
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_level", 64'(level), 64'(0));
        check("t6_async_valid", 64'(m_valid), 64'(0));
        check("t6_async_ready", 64'(s_ready), 64'(1));
        check("t6_async_data", 64'(m_data), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'h77; tick();
        s_valid = 1'b0;
        check("t6_first_level", 64'(level), 64'(1));
        check("t6_first_data", 64'(m_data), 64'(8'h77));
        m_ready = 1'b1; tick(); m_ready = 1'b0;

        // Short random run on the DEPTH=16 instance.
        for (int c = 0; c < 3000; c++) begin
            int seg;
            seg     = (c / 300) % 2;
            s_valid = ($urandom_range(0, 99) < ((seg == 0) ? 70 : 30));
            m_ready = ($urandom_range(0, 99) < ((seg == 0) ? 30 : 70));
            flush   = ($urandom_range(0, 299) == 0);
            s_data  = W'($urandom_range(0, 255));
            tick();
        end
        s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
        repeat (D + 2) tick();
        check("t7_drained", 64'(level), 64'(0));
        m_ready = 1'b0;

        // Wait (bounded) for the randomised instances to finish.
        for (int t = 0; t < 20000; t++) begin
            if (g_rand[0].done && g_rand[1].done) break;
            @(posedge clk);
        end
        check("rand_done", 64'(g_rand[0].done && g_rand[1].done), 64'(1));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
